// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM state encoding, RAM depth
// derivation and round-robin pointer width.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        INIT       = 2'd1,
        RUN        = 2'd2
    } arb_state_e;

    // Number of RAM words addressed by an ADDR_WIDTH-bit address.
    function automatic int unsigned ram_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Width of a requester index; a single requester still needs one bit.
    function automatic int unsigned arb_idx_width(input int unsigned num_req);
        return (num_req > 32'd1) ? 32'($clog2(num_req)) : 32'd1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: packed valid/ready request channels
// plus the one-cycle read response. master = requesters, slave = arbiter.
interface ram_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 2
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first active request after `last`,
// wrapping around. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int unsigned cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 32'd0;
        // k = NUM_REQ wraps back onto `last` itself, so it has lowest priority
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last) + k) % NUM_REQ;
            if (!grant_valid && req[IDX_W'(cand)]) begin
                grant[IDX_W'(cand)] = 1'b1;
                grant_idx           = IDX_W'(cand);
                grant_valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between NUM_REQ requesters.
// Define RAM_ARB_INIT_EN to zero-fill the RAM after reset and on each clr.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_arbiter_if.slave          bus,
    input  logic                  clr,
    output logic                  init_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned IDX_W = arb_idx_width(NUM_REQ);

    arb_state_e            state;
    arb_state_e            state_next;
    logic [IDX_W-1:0]      last;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [NUM_REQ-1:0]    ready;
    logic [NUM_REQ-1:0]    accept;
    logic [NUM_REQ-1:0]    rsp_q;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_din;

`ifdef RAM_ARB_INIT_EN
    localparam int unsigned DEPTH = ram_depth(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  fill_last;

    assign fill_last = (fill_cnt == ADDR_WIDTH'(DEPTH - 32'd1));

    // Fill address; parked at 0 outside INIT so every fill starts from the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (state == INIT) begin
            fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
        end else begin
            fill_cnt <= '0;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (bus.req_valid),
        .last        (last),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
`ifdef RAM_ARB_INIT_EN
            RESET_HOLD: state_next = INIT;
            INIT:       if (fill_last) state_next = RUN;
            RUN:        if (clr) state_next = INIT;
`else
            RESET_HOLD: state_next = RUN;
            RUN:        state_next = RUN;
`endif
            default:    state_next = RESET_HOLD;
        endcase
    end

    // Winner's request fields, selected by the one-hot grant
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we   = bus.req_we[i];
                sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_din  = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM outputs: RAM pins and request ready
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = hold_addr;
        ram_din  = hold_din;
        ready    = '0;
        case (state)
            RESET_HOLD: begin
                ram_addr = '0;
                ram_din  = '0;
            end
`ifdef RAM_ARB_INIT_EN
            INIT: begin
                ram_we   = 1'b1;
                ram_addr = fill_cnt;
                ram_din  = '0;
            end
`endif
            RUN: begin
                if (grant_valid) begin
                    ram_we   = sel_we;
                    ram_addr = sel_addr;
                    ram_din  = sel_din;
                    ready    = grant;
                end
            end
            default: begin
                ram_addr = '0;
                ram_din  = '0;
            end
        endcase
    end

    assign accept = ready & bus.req_valid;

    // Idle RUN cycles keep the last address/data on the RAM pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_din  <= '0;
        end else begin
            hold_addr <= ram_addr;
            hold_din  <= ram_din;
        end
    end

    // Round-robin pointer and read-response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last  <= IDX_W'(NUM_REQ - 32'd1);
            rsp_q <= '0;
        end else begin
            if (|accept) begin
                last <= grant_idx;
            end
            rsp_q <= accept & ~bus.req_we;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = (|rsp_q) ? ram_dout : '0;
    assign init_done     = (state == RUN);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM; covers
// both builds (RAM_ARB_INIT_EN defined or not).
module tb_ram_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 2;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          init_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int n_checks;
    int n_fail;

    ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr       (clr),
        .init_done (init_done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Synchronous RAM: registered read, write on the same edge
    logic [DW-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [1:0] e_ready;
        logic       e_we;
        logic [3:0] e_addr;
        logic [1:0] e_rsp;
        logic [7:0] e_rdata;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] valid, input logic [1:0] we,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [7:0] w0, input logic [7:0] w1);
        bus.req_valid = valid;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {w1, w0};
    endtask

    // Called in the first INIT cycle; returns sampled in the first RUN cycle
    task automatic wait_fill(input string tag);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s addr%0d", tag, k), 32'(ram_addr), 32'(k));
            check($sformatf("%s we%0d", tag, k), 32'(ram_we), 32'd1);
            check($sformatf("%s ready%0d", tag, k), 32'(bus.req_ready), 32'd0);
            check($sformatf("%s done%0d", tag, k), 32'(init_done), 32'd0);
            @(negedge clk); #1;
        end
        check({tag, " init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tbl[0]  = '{2'b01, 2'b01, 4'd2, 4'd0, 8'hAA, 8'h00, 2'b01, 1'b1, 4'd2,  2'b00, 8'h00};
        tbl[1]  = '{2'b10, 2'b10, 4'd0, 4'd4, 8'h00, 8'h55, 2'b10, 1'b1, 4'd4,  2'b00, 8'h00};
        tbl[2]  = '{2'b01, 2'b00, 4'd2, 4'd0, 8'h00, 8'h00, 2'b01, 1'b0, 4'd2,  2'b00, 8'h00};
        tbl[3]  = '{2'b10, 2'b00, 4'd0, 4'd4, 8'h00, 8'h00, 2'b10, 1'b0, 4'd4,  2'b01, 8'hAA};
        tbl[4]  = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd4,  2'b10, 8'h55};
        tbl[5]  = '{2'b11, 2'b00, 4'd2, 4'd4, 8'h00, 8'h00, 2'b01, 1'b0, 4'd2,  2'b00, 8'h00};
        tbl[6]  = '{2'b11, 2'b00, 4'd2, 4'd4, 8'h00, 8'h00, 2'b10, 1'b0, 4'd4,  2'b01, 8'hAA};
        tbl[7]  = '{2'b11, 2'b00, 4'd2, 4'd4, 8'h00, 8'h00, 2'b01, 1'b0, 4'd2,  2'b10, 8'h55};
        tbl[8]  = '{2'b11, 2'b00, 4'd2, 4'd4, 8'h00, 8'h00, 2'b10, 1'b0, 4'd4,  2'b01, 8'hAA};
        tbl[9]  = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd4,  2'b10, 8'h55};
        tbl[10] = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd4,  2'b00, 8'h00};
        tbl[11] = '{2'b01, 2'b01, 4'd15, 4'd0, 8'h3C, 8'h00, 2'b01, 1'b1, 4'd15, 2'b00, 8'h00};
        tbl[12] = '{2'b10, 2'b00, 4'd0, 4'd15, 8'h00, 8'h00, 2'b10, 1'b0, 4'd15, 2'b00, 8'h00};
        tbl[13] = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd15, 2'b10, 8'h3C};

        rst_n = 1'b0;
        clr   = 1'b0;
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        check("rst ram_we", 32'(ram_we), 32'd0);
        check("rst ram_addr", 32'(ram_addr), 32'd0);
        check("rst init_done", 32'(init_done), 32'd0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        #1;
        check("hold ready", 32'(bus.req_ready), 32'd0);
        check("hold init_done", 32'(init_done), 32'd0);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        @(negedge clk); #1;
`ifdef RAM_ARB_INIT_EN
        wait_fill("fill0");
        drive(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00);
        #1;
        check("rd7 ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        #1;
        check("rd7 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd7 rdata", 32'(bus.rsp_rdata), 32'h00);
`else
        check("noinit init_done", 32'(init_done), 32'd1);
`endif

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].w0, tbl[i].w1);
            #1;
            check($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'(tbl[i].e_ready));
            check($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(tbl[i].e_we));
            check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
            check($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].e_rsp));
            if (tbl[i].e_rsp != 2'b00)
                check($sformatf("v%0d rdata", i), 32'(bus.rsp_rdata), 32'(tbl[i].e_rdata));
        end

        // clr coinciding with an accepted read of addr 2
        @(negedge clk);
        drive(2'b01, 2'b00, 4'd2, 4'd0, 8'h00, 8'h00);
        clr = 1'b1;
        #1;
        check("clr ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        clr = 1'b0;
        #1;
        check("clr rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("clr rdata", 32'(bus.rsp_rdata), 32'hAA);
`ifdef RAM_ARB_INIT_EN
        wait_fill("fill_clr");
        drive(2'b01, 2'b00, 4'd2, 4'd0, 8'h00, 8'h00);
        #1;
        check("reread ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        #1;
        check("reread rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("reread rdata", 32'(bus.rsp_rdata), 32'h00);
`else
        check("clr init_done", 32'(init_done), 32'd1);
        check("clr ram_we", 32'(ram_we), 32'd0);
        @(negedge clk); #1;
        check("clr still run", 32'(init_done), 32'd1);
`endif

        // Async reset with a read response in flight
        @(negedge clk);
        drive(2'b10, 2'b00, 4'd0, 4'd4, 8'h00, 8'h00);
        @(posedge clk); #1;
        check("flight rsp_valid", 32'(bus.rsp_valid), 32'd2);
        rst_n = 1'b0;
        #1;
        check("flight rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("flight rst ready", 32'(bus.req_ready), 32'd0);
        check("flight rst ram_we", 32'(ram_we), 32'd0);
        check("flight rst init_done", 32'(init_done), 32'd0);
        drive(2'b11, 2'b00, 4'd0, 4'd1, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
`ifdef RAM_ARB_INIT_EN
        wait_fill("fill_rst");
        check("post rst ready", 32'(bus.req_ready), 32'd1);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);

        // Reset dropped mid-fill at address 9
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); #1;
        end
        check("mid addr9", 32'(ram_addr), 32'd9);
        rst_n = 1'b0;
        #1;
        check("mid rst ram_we", 32'(ram_we), 32'd0);
        check("mid rst ram_addr", 32'(ram_addr), 32'd0);
        check("mid rst init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        wait_fill("fill_restart");
`else
        check("post rst init_done", 32'(init_done), 32'd1);
        check("post rst ready", 32'(bus.req_ready), 32'd1);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares one `synchronous_ram` instance between `NUM_REQ` requesters. Each requester uses a valid/ready request channel and receives a one-cycle read response pulse. The block sits directly in front of the RAM and drives its `we`/`addr`/`din` pins. Optionally, it zero-fills the RAM after reset or on command before granting any access.

## Interface
- `DATA_WIDTH`, 8, RAM word width
- `ADDR_WIDTH`, 4, RAM address width; depth = 2^ADDR_WIDTH
- `NUM_REQ`, 2, number of requesters (2..8)

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- `rsp_valid`  out  NUM_REQ  one-cycle read-data pulse to the owning requester
- `rsp_rdata`  out  DATA_WIDTH  read data; meaningful only while any `rsp_valid` bit is high
- `clr`  in  1  request a re-fill; ignored without `RAM_ARB_INIT_EN`
- `init_done`  out  1  high while in RUN
- `ram_we`, `ram_addr`, `ram_din`  out  1/ADDR_WIDTH/DATA_WIDTH  to RAM `we`/`addr`/`din`
- `ram_dout`  in  DATA_WIDTH  from RAM `dout`

## Operation
- FSM states:
  - RESET_HOLD is the reset state.
  - INIT is the fill state.
  - RUN is normal operation.
- FSM transitions:
  - RESET_HOLD → INIT on the first edge after reset release when the macro is defined; otherwise RESET_HOLD → RUN.
  - INIT → RUN on the edge that writes address DEPTH-1.
  - RUN → INIT on an edge with `clr`=1 (macro only).
- RESET_HOLD outputs: `ram_we`=0, `ram_addr`=0, `ram_din`=0, `req_ready`=0.
- INIT outputs: `ram_we`=1, `ram_addr`=fill counter, `ram_din`=0, `req_ready`=0.
  - The fill counter starts at 0 and increments once per cycle, taking DEPTH cycles.
- Arbitration in RUN:
  - The round-robin pointer `last` resets to NUM_REQ-1, so requester 0 wins first.
  - The winner is the first i with `req_valid[i]`=1, searching from `last`+1 with wrap-around.
  - `req_ready[winner]`=1. RAM pins are driven combinationally from the winner's `req_we`/`req_addr`/`req_wdata`.
  - With no valid request: `ram_we`=0 and RAM address/data hold the previous value (no read side effect is required).
- Acceptance: a request is accepted on an edge where `req_valid[i]`&`req_ready[i]`.
  - On acceptance, `last` ← i.
  - A requester must hold valid, we, addr and wdata stable until accepted.
- Reads: `rsp_valid[i]` is registered high for the cycle after acceptance. `rsp_rdata` = `ram_dout` passed through combinationally.
- Writes produce no response.
- Responses have no backpressure.
- `clr` in the same edge as an acceptance: the access completes first, including its read response in the first INIT cycle; the fill follows.
- `clr` while already in INIT has no effect; the fill is not restarted.

## Timing
- Read latency: acceptance at edge N gives `rsp_valid` high and data valid in the cycle N..N+1.
- Throughput: one accepted access per cycle in RUN.
- Back-to-back accesses from different requesters need no bubble.
- Fill: exactly DEPTH cycles from entering INIT to `init_done`=1 (16 for defaults).
- Async reset asserted mid-operation:
  - `rsp_valid`, `req_ready`, `ram_we` and `init_done` go to 0 immediately.
  - `last` goes to NUM_REQ-1.
  - Any in-flight response is dropped.
  - A fill in progress restarts from address 0 after release.
- Reset values of all outputs are 0.

## Configuration
- Macro `RAM_ARB_INIT_EN`.
- Defined: INIT state and fill counter are present; zero-fill after every reset and on each `clr`; `init_done` asserts after the fill.
- Undefined: no INIT state and no counter; `clr` is ignored; `init_done`=1 from the first edge after reset release onward.

## Structure
- Package `ram_arb_pkg`: state enum typedef (RESET_HOLD, INIT, RUN) and `RAM_DEPTH` derivation from ADDR_WIDTH.
- Sub-module `rr_arbiter`: NUM_REQ-way combinational round-robin grant from request vector and `last` pointer; pointer register stays in the top level.

## Test plan
- Reset release with macro: 16 cycles with `ram_we`=1 and addr 0..15; then `init_done`=1; a read of addr 7 returns 8'h00.
- Requester 0 writes 8'hAA @2, requester 1 writes 8'h55 @4, then both read back: data AA and 55 returned with latency 1 to the correct `rsp_valid` bit.
- Both requesters hold `req_valid` continuously: grants alternate 0,1,0,1 with one acceptance per cycle; none starves.
- `clr` pulsed in the same cycle as an accepted read of addr 2 (8'hAA): the read returns AA; a 16-cycle fill follows; a re-read of addr 2 returns 00.
- `rst_n` dropped at fill address 9: outputs go to 0 immediately; after release the fill restarts at address 0.
- Without the macro: `init_done`=1 one cycle after reset release; `clr`=1 causes no fill; a write/read of 8'h3C @15 round-trips.
